// File: rtl/ps2_key_rx.sv
// PS/2 device-to-host receiver producing the {toggle, pressed, extended, code} key event word.
// Define PS2_REPEAT_FILTER_EN to suppress typematic repeats of the most recently made key.
module ps2_key_rx #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 24000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ps2_clk_in,
    input  logic        ps2_data_in,
    output logic [10:0] ps2_key,
    output logic        frame_err,
    output logic        busy
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]    clk_sync_q, clk_sync_d;
    logic [1:0]    data_sync_q, data_sync_d;
    logic          filt_q, filt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          fall;
    logic          data_bit;

    state_t        state_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          parity_q;
    logic [TW-1:0] to_cnt_q;
    logic          ext_q, brk_q;
    logic [10:0]   key_q;
    logic          err_q;
`ifdef PS2_REPEAT_FILTER_EN
    logic          held_vld_q;
    logic [8:0]    held_q;
`endif

    // The filtered clock only moves once the synchronized line has disagreed with it for FILTER_LEN samples.
    always_comb begin
        clk_sync_d  = {clk_sync_q[0], ps2_clk_in};
        data_sync_d = {data_sync_q[0], ps2_data_in};
        filt_d      = filt_q;
        fcnt_d      = '0;
        fall        = 1'b0;
        if (clk_sync_q[1] != filt_q) begin
            if (fcnt_q == FW'(FILTER_LEN - 1)) begin
                filt_d = ~filt_q;
                fall   = filt_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    assign data_bit = data_sync_q[1];

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            filt_q      <= 1'b1;
            fcnt_q      <= '0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            filt_q      <= filt_d;
            fcnt_q      <= fcnt_d;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            to_cnt_q   <= '0;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            key_q      <= '0;
            err_q      <= 1'b0;
`ifdef PS2_REPEAT_FILTER_EN
            held_vld_q <= 1'b0;
            held_q     <= '0;
`endif
        end else begin
            err_q <= 1'b0;
            if (fall) begin
                to_cnt_q <= '0;
            end else if (state_q != IDLE) begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end

            if (!fall && state_q != IDLE && to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                state_q  <= IDLE;
                to_cnt_q <= '0;
                err_q    <= 1'b1;
                ext_q    <= 1'b0;
                brk_q    <= 1'b0;
            end else if (fall) begin
                case (state_q)
                    IDLE: begin
                        if (!data_bit) begin
                            state_q   <= DATA;
                            bit_cnt_q <= '0;
                        end
                    end
                    DATA: begin
                        shift_q   <= {data_bit, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) state_q <= PARITY;
                    end
                    PARITY: begin
                        parity_q <= data_bit;
                        state_q  <= STOP;
                    end
                    default: begin
                        state_q <= IDLE;
                        // Odd parity over data+parity and a high stop bit make a good frame.
                        if (!(data_bit && ^{shift_q, parity_q})) begin
                            err_q <= 1'b1;
                            ext_q <= 1'b0;
                            brk_q <= 1'b0;
                        end else if (shift_q == 8'hE0) begin
                            ext_q <= 1'b1;
                        end else if (shift_q == 8'hF0) begin
                            brk_q <= 1'b1;
                        end else begin
                            ext_q <= 1'b0;
                            brk_q <= 1'b0;
`ifdef PS2_REPEAT_FILTER_EN
                            if (brk_q) begin
                                key_q <= {~key_q[10], 1'b0, ext_q, shift_q};
                                if ({ext_q, shift_q} == held_q) held_vld_q <= 1'b0;
                            end else if (!(held_vld_q && {ext_q, shift_q} == held_q)) begin
                                key_q      <= {~key_q[10], 1'b1, ext_q, shift_q};
                                held_q     <= {ext_q, shift_q};
                                held_vld_q <= 1'b1;
                            end
`else
                            key_q <= {~key_q[10], ~brk_q, ext_q, shift_q};
`endif
                        end
                    end
                endcase
            end
        end
    end

    assign ps2_key   = key_q;
    assign frame_err = err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_key_rx.sv
// Directed bench for ps2_key_rx: PS/2 frames are bit-banged at a shortened bit period.
module tb_ps2_key_rx;
    localparam int HALF = 20;
    localparam int GAP  = 40;
    localparam int TOUT = 24000;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ps2_clk_in = 1'b1;
    logic        ps2_data_in = 1'b1;
    logic [10:0] ps2_key;
    logic        frame_err;
    logic        busy;

    int n_checks = 0;
    int n_pass = 0;
    int err_pulses = 0;
    int flips = 0;
    logic last_tog = 1'b0;

    ps2_key_rx dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_key     (ps2_key),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    always #5 clk_sys = ~clk_sys;

    always @(negedge clk_sys) begin
        if (frame_err) err_pulses++;
        if (ps2_key[10] != last_tog) flips++;
        last_tog = ps2_key[10];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic ps2_bit(input logic b, input bit glitch);
        ps2_data_in = b;
        if (glitch) begin
            wait_cyc(5);
            ps2_clk_in = 1'b0;
            wait_cyc(2);
            ps2_clk_in = 1'b1;
            wait_cyc(HALF - 7);
        end else begin
            wait_cyc(HALF);
        end
        ps2_clk_in = 1'b0;
        wait_cyc(HALF);
        ps2_clk_in = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] code, input logic par_flip, input logic stop,
                              input bit glitch);
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(code[i], glitch && i == 4);
        ps2_bit(~^code ^ par_flip, 1'b0);
        ps2_bit(stop, 1'b0);
        ps2_data_in = 1'b1;
        wait_cyc(GAP);
    endtask

    task automatic send_byte(input logic [7:0] code);
        send_frame(code, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        int base;
        int n;
        logic [7:0] c75;
        c75 = 8'h75;
        wait_cyc(5);
        reset_n = 1'b1;
        wait_cyc(5);

        // Reset in the middle of a frame, after one decoded make.
        send_byte(8'h1C);
        chk("first_make", ps2_key, 11'h61C);
        ps2_bit(1'b0, 1'b0);
        ps2_bit(1'b1, 1'b0);
        ps2_bit(1'b0, 1'b0);
        ps2_data_in = 1'b1;
        wait_cyc(2);
        chk("busy_mid", busy, 1);
        reset_n = 1'b0;
        wait_cyc(3);
        reset_n = 1'b1;
        wait_cyc(2);
        chk("rst_key", ps2_key, 11'h000);
        chk("rst_busy", busy, 0);
        chk("rst_err", frame_err, 0);

        // Make / break.
        send_byte(8'h1C);
        chk("make_1c", ps2_key, 11'h61C);
        send_byte(8'hF0);
        chk("f0_hold", ps2_key, 11'h61C);
        send_byte(8'h1C);
        chk("break_1c", ps2_key, 11'h01C);

        // Extended make / break.
        send_byte(8'hE0);
        send_byte(8'h75);
        chk("ext_make", ps2_key, 11'h775);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        chk("ext_break", ps2_key, 11'h175);

        // Bad parity, bad stop, glitched clock.
        base = err_pulses;
        send_frame(8'h29, 1'b1, 1'b1, 1'b0);
        chk("par_err_pulses", err_pulses - base, 1);
        chk("par_err_key", ps2_key, 11'h175);
        base = err_pulses;
        send_frame(8'h29, 1'b0, 1'b0, 1'b0);
        chk("stop_err_pulses", err_pulses - base, 1);
        chk("stop_err_key", ps2_key, 11'h175);
        base = err_pulses;
        send_frame(8'h29, 1'b0, 1'b1, 1'b1);
        chk("glitch_key", ps2_key, 11'h629);
        chk("glitch_no_err", err_pulses - base, 0);

        // Timeout after E0 and four data bits; the filtered fall lands 6 edges after the raw fall.
        send_byte(8'hE0);
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(c75[i], 1'b0);
        ps2_data_in = c75[3];
        wait_cyc(HALF);
        ps2_clk_in = 1'b0;
        n = 0;
        while (n < TOUT + 100) begin
            @(posedge clk_sys);
            n++;
            @(negedge clk_sys);
            if (frame_err) break;
        end
        chk("timeout_lat", n, TOUT + 6);
        wait_cyc(1);
        chk("timeout_pulse_len", frame_err, 0);
        chk("timeout_busy", busy, 0);
        ps2_clk_in = 1'b1;
        ps2_data_in = 1'b1;
        wait_cyc(GAP);
        send_byte(8'h75);
        chk("after_timeout", ps2_key, 11'h275);

        // Typematic repeats.
        base = flips;
        send_byte(8'h1C);
        send_byte(8'h1C);
        send_byte(8'h1C);
        send_byte(8'hF0);
        send_byte(8'h1C);
`ifdef PS2_REPEAT_FILTER_EN
        chk("repeat_flips", flips - base, 2);
`else
        chk("repeat_flips", flips - base, 4);
`endif
        chk("repeat_final", ps2_key, 11'h01C);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
